// File: rtl/div_if.sv
// Handshake and data bundle between the EX-stage control and the iterative divider.
// The master drives the operands, start and cancel; the slave returns busy, done and the results.
// The divider acts as the slave. Pipeline control acts as the master.
interface div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic             cancel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;

  modport master (
    output start, signed_op, cancel, a, b,
    input  busy, done, q, r
  );

  modport slave (
    input  start, signed_op, cancel, a, b,
    output busy, done, q, r
  );
endinterface

// File: rtl/div.sv
// Iterative radix-2 restoring divider for DIV/DIVU. It produces the quotient (LO) and the remainder (HI).
// Latency: start is sampled at edge 0, busy is high for cycles 1..WIDTH, and done pulses in cycle WIDTH+1.
// Backpressure: there is none. The pipeline stalls on busy. start is ignored during RUN, and cancel aborts a run.
module div #(
  parameter int WIDTH = 32
) (
  input  logic i_clk,
  input  logic i_resetn,
  div_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load;      // capture operands this cycle
  logic             w_last;      // final iteration; results are committed at this edge

  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem;       // partial remainder; the extra bit holds the borrow
  logic [WIDTH-1:0] r_dvd;       // dividend magnitude shifts out while quotient bits shift in
  logic [WIDTH-1:0] r_dvs;       // divisor magnitude
  logic             r_signed;
  logic             r_sign_a;    // sign of the dividend, which the remainder follows
  logic             r_sign_x;    // sign(a) ^ sign(b), which selects quotient negation
  logic             r_dvs_zero;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_dvd_nxt;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // Take operand magnitudes. The most negative value maps to itself, which is still the correct unsigned magnitude.
  always_comb begin
    w_abs_a = bus.a;
    w_abs_b = bus.b;
    if (bus.signed_op && bus.a[WIDTH-1]) w_abs_a = -bus.a;
    if (bus.signed_op && bus.b[WIDTH-1]) w_abs_b = -bus.b;
  end

  // One restoring step: shift in the next dividend bit and keep the difference when it does not borrow.
  always_comb begin
    w_shift   = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
    w_diff    = w_shift - {1'b0, r_dvs};
    w_qbit    = ~w_diff[WIDTH];
    w_rem_nxt = w_qbit ? w_diff : w_shift;
    w_dvd_nxt = {r_dvd[WIDTH-2:0], w_qbit};
  end

  // Sign fix-up of the final step. Division by zero forces q to all ones.
  // The remainder then already equals |a|, and re-signing it returns the original dividend.
  always_comb begin
    w_q_fix = w_dvd_nxt;
    w_r_fix = w_rem_nxt[WIDTH-1:0];
    if (r_signed && r_sign_x) w_q_fix = -w_dvd_nxt;
    if (r_signed && r_sign_a) w_r_fix = -w_rem_nxt[WIDTH-1:0];
    if (r_dvs_zero)           w_q_fix = {WIDTH{1'b1}};
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next-state logic. cancel wins over start, and a start in DONE chains straight into the next run.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.start && !bus.cancel) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.cancel) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == LAST_CNT) begin
          w_state_nxt = ST_DONE;
          w_last      = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture on start, iterate during RUN, and commit q/r only when entering DONE.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_signed   <= 1'b0;
      r_sign_a   <= 1'b0;
      r_sign_x   <= 1'b0;
      r_dvs_zero <= 1'b0;
      r_q        <= '0;
      r_r        <= '0;
    end else if (w_load) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_dvd      <= w_abs_a;
      r_dvs      <= w_abs_b;
      r_signed   <= bus.signed_op;
      r_sign_a   <= bus.a[WIDTH-1];
      r_sign_x   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      r_dvs_zero <= (bus.b == '0);
    end else if (r_state == ST_RUN && !bus.cancel) begin
      r_cnt <= r_cnt + CW'(1);
      r_rem <= w_rem_nxt;
      r_dvd <= w_dvd_nxt;
      if (w_last) begin
        r_q <= w_q_fix;
        r_r <= w_r_fix;
      end
    end
  end

  assign bus.busy = (r_state == ST_RUN);
  assign bus.done = (r_state == ST_DONE);
  assign bus.q    = r_q;
  assign bus.r    = r_r;

endmodule

// File: tb/tb_div.sv
// Bench for the divider. Expected q/r come from a behavioural model and are queued when start is driven.
// They are compared when done pulses, and the latency and busy window are checked for every operation.
module tb_div;

  logic clk;
  logic resetn;
  int   n_err;
  int   n_chk;
  logic [63:0] sb[$];
  logic [31:0] last_q;
  logic [31:0] last_r;

  div_if #(.WIDTH(32)) bus ();

  div #(.WIDTH(32)) u_dut (
    .i_clk    (clk),
    .i_resetn (resetn),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mq;
    logic [31:0] mr;
    if (b == 32'h0) return {32'hFFFF_FFFF, a};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
      mq = 32'($signed(a) / $signed(b));
      mr = 32'($signed(a) % $signed(b));
    end else begin
      mq = a / b;
      mr = a % b;
    end
    return {mq, mr};
  endfunction

  // Called #1 after an edge. start is sampled at the next edge (edge 0), and the task returns in cycle 1.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    bus.start     = 1'b1;
    bus.signed_op = s;
    bus.a         = a;
    bus.b         = b;
    sb.push_back(model(s, a, b));
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.signed_op = ~s;
    bus.a         = $urandom;
    bus.b         = $urandom;
  endtask

  // Waits for done, starting in cycle 1. When poke is nonzero, a stray start is pulsed at that cycle.
  task automatic wait_done(input int poke);
    int k;
    int nbusy;
    logic [63:0] e;
    k = 1;
    nbusy = 0;
    while (bus.done !== 1'b1 && k <= 40) begin
      if (bus.busy === 1'b1) nbusy++;
      if (poke != 0 && k == poke) begin
        bus.start = 1'b1;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
      end else if (poke != 0 && k == poke + 1) begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    bus.start = 1'b0;
    if (bus.done === 1'b1) begin
      check("latency", 64'(k), 64'd33);
      check("busy_cycles", 64'(nbusy), 64'd32);
      check("busy_at_done", 64'(bus.busy), 64'd0);
      if (sb.size() == 0) begin
        check("scoreboard_empty", 64'd0, 64'd1);
      end else begin
        e = sb.pop_front();
        check("q", 64'(bus.q), 64'(e[63:32]));
        check("r", 64'(bus.r), 64'(e[31:0]));
        last_q = e[63:32];
        last_r = e[31:0];
      end
    end else begin
      check("done_timeout", 64'd0, 64'd1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int seen;
    logic s;
    logic [31:0] ra;
    logic [31:0] rb;
    n_err  = 0;
    n_chk  = 0;
    last_q = '0;
    last_r = '0;
    resetn        = 1'b0;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.cancel    = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    #3;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_q", 64'(bus.q), 64'd0);
    check("rst_r", 64'(bus.r), 64'd0);
    #10 resetn = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    issue(1'b0, 32'd100, 32'd7);                  wait_done(0);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);            wait_done(0);
    issue(1'b1, 32'd7, 32'hFFFF_FFFE);            wait_done(0);
    issue(1'b0, 32'd5, 32'd0);                    wait_done(0);
    issue(1'b1, 32'hFFFF_FFF9, 32'd0);            wait_done(0);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);    wait_done(0);
    issue(1'b0, 32'hFFFF_FFFF, 32'h10);           wait_done(0);
    // Back-to-back: start again in the DONE cycle.
    issue(1'b0, 32'd9, 32'd3);                    wait_done(0);

    // A stray start during RUN must not disturb the operation in flight.
    issue(1'b0, 32'd1000, 32'd10);                wait_done(5);

    // cancel in cycle 10 gives busy low in cycle 11, no done, and held results.
    issue(1'b0, 32'd50, 32'd3);
    void'(sb.pop_back());
    repeat (9) begin @(posedge clk); #1; end
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    check("cancel_busy", 64'(bus.busy), 64'd0);
    check("cancel_q_hold", 64'(bus.q), 64'(last_q));
    check("cancel_r_hold", 64'(bus.r), 64'(last_r));
    seen = 0;
    repeat (40) begin
      if (bus.done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    check("cancel_no_done", 64'(seen), 64'd0);
    issue(1'b0, 32'd20, 32'd6);                   wait_done(0);

    // When start and cancel arrive together in IDLE, cancel wins.
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    bus.a      = 32'd8;
    bus.b      = 32'd2;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    check("startcancel_busy", 64'(bus.busy), 64'd0);
    seen = 0;
    repeat (36) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      @(posedge clk); #1;
    end
    check("startcancel_idle", 64'(seen), 64'd0);

    // Pulse the reset low mid-run, in cycle 15.
    issue(1'b0, 32'd1000, 32'd3);
    void'(sb.pop_back());
    repeat (14) begin @(posedge clk); #1; end
    resetn = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_q", 64'(bus.q), 64'd0);
    check("midrst_r", 64'(bus.r), 64'd0);
    resetn = 1'b1;
    last_q = '0;
    last_r = '0;
    @(posedge clk); #1;
    issue(1'b0, 32'd1, 32'd1);                    wait_done(0);

    // Random operands in both modes, including zero, small and negative divisors.
    for (int i = 0; i < 24; i++) begin
      s  = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = $urandom;
        default: rb = $urandom | 32'hFFFF_FF00;
      endcase
      issue(s, ra, rb);
      wait_done(0);
      if (i % 3 == 0) begin @(posedge clk); #1; end
    end

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
